// File: rtl/sdr_rx_demux.sv
// Receive-side 1:2 AXIS demultiplexer: routes whole inbound frames to DMA, ALT or discard.
// Destination is latched on a frame's first beat; one holding register feeds both masters.
module sdr_rx_demux #(
  parameter int AXIS_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_enable,
  input  logic [1:0]              cfg_dst_sel,
  input  logic                    stat_clr,
  input  logic [AXIS_BYTES*8-1:0] s_axis_in_tdata,
  input  logic [AXIS_BYTES-1:0]   s_axis_in_tkeep,
  input  logic                    s_axis_in_tvalid,
  input  logic                    s_axis_in_tlast,
  output logic                    s_axis_in_tready,
  output logic [AXIS_BYTES*8-1:0] m_axis_dma_tdata,
  output logic [AXIS_BYTES-1:0]   m_axis_dma_tkeep,
  output logic                    m_axis_dma_tvalid,
  output logic                    m_axis_dma_tlast,
  input  logic                    m_axis_dma_tready,
  output logic [AXIS_BYTES*8-1:0] m_axis_alt_tdata,
  output logic [AXIS_BYTES-1:0]   m_axis_alt_tkeep,
  output logic                    m_axis_alt_tvalid,
  output logic                    m_axis_alt_tlast,
  input  logic                    m_axis_alt_tready,
  output logic [31:0]             stat_bytes,
  output logic [31:0]             stat_frames,
  output logic [31:0]             stat_dropped,
  output logic                    stat_in_frame,
  output logic [1:0]              stat_dst_active
);

  localparam logic [1:0] DST_DMA = 2'd0;
  localparam logic [1:0] DST_ALT = 2'd1;

  typedef enum logic {ST_IDLE = 1'b0, ST_PASS = 1'b1} state_t;

  function automatic logic [31:0] f_popcount(input logic [AXIS_BYTES-1:0] keep);
    logic [31:0] cnt;
    cnt = 32'd0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      cnt = cnt + {31'd0, keep[i]};
    end
    return cnt;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_locked_dst;
  logic [1:0]              w_locked_nxt;
  logic                    r_active;
  logic [AXIS_BYTES*8-1:0] r_data;
  logic [AXIS_BYTES-1:0]   r_keep;
  logic                    r_last;
  logic                    r_valid_q;
  logic [1:0]              r_q_dst;
  logic [31:0]             r_bytes;
  logic [31:0]             r_frames;
  logic [31:0]             r_dropped;

  logic [1:0] w_route_dst;
  logic       w_route_drop;
  logic       w_en_ok;
  logic       w_drain;
  logic       w_can_load;
  logic       w_tready;
  logic       w_accept;
  logic       w_load;
  logic       w_drop;

  // Routing, enable gating and holding-stage handshake
  always_comb begin
    w_route_dst  = (r_state == ST_PASS) ? r_locked_dst : cfg_dst_sel;
    w_route_drop = w_route_dst[1];
    w_en_ok      = (r_state == ST_PASS) | cfg_enable;
    w_drain      = r_valid_q & (((r_q_dst == DST_DMA) & m_axis_dma_tready) |
                                ((r_q_dst == DST_ALT) & m_axis_alt_tready));
    w_can_load   = ~r_valid_q | w_drain;
    // r_active keeps tready low while reset is asserted and for the first edge after
    w_tready     = r_active & w_en_ok & (w_route_drop | w_can_load);
    w_accept     = s_axis_in_tvalid & w_tready;
    w_load       = w_accept & ~w_route_drop;
    w_drop       = w_accept & w_route_drop;
  end

  // Frame FSM next-state
  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = r_locked_dst;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !s_axis_in_tlast) begin
          w_state_nxt  = ST_PASS;
          w_locked_nxt = cfg_dst_sel;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (w_accept && s_axis_in_tlast) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PASS;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_locked_dst <= 2'd0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_locked_dst <= w_locked_nxt;
      r_active     <= 1'b1;
    end
  end

  // Holding register: load wins over drain so both can happen in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_keep    <= '0;
      r_last    <= 1'b0;
      r_valid_q <= 1'b0;
      r_q_dst   <= 2'd0;
    end else if (w_load) begin
      r_data    <= s_axis_in_tdata;
      r_keep    <= s_axis_in_tkeep;
      r_last    <= s_axis_in_tlast;
      r_valid_q <= 1'b1;
      r_q_dst   <= w_route_dst;
    end else if (w_drain) begin
      r_valid_q <= 1'b0;
    end else begin
      r_valid_q <= r_valid_q;
    end
  end

  // Statistics counters; clear has priority over any increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bytes   <= 32'd0;
      r_frames  <= 32'd0;
      r_dropped <= 32'd0;
    end else if (stat_clr) begin
      r_bytes   <= 32'd0;
      r_frames  <= 32'd0;
      r_dropped <= 32'd0;
    end else begin
      if (w_drain) begin
        r_bytes <= r_bytes + f_popcount(r_keep);
      end
      if (w_drain && r_last) begin
        r_frames <= r_frames + 32'd1;
      end
      if (w_drop) begin
        r_dropped <= r_dropped + 32'd1;
      end
    end
  end

  assign s_axis_in_tready  = w_tready;
  assign m_axis_dma_tdata  = r_data;
  assign m_axis_dma_tkeep  = r_keep;
  assign m_axis_dma_tlast  = r_last;
  assign m_axis_dma_tvalid = r_valid_q & (r_q_dst == DST_DMA);
  assign m_axis_alt_tdata  = r_data;
  assign m_axis_alt_tkeep  = r_keep;
  assign m_axis_alt_tlast  = r_last;
  assign m_axis_alt_tvalid = r_valid_q & (r_q_dst == DST_ALT);
  assign stat_bytes        = r_bytes;
  assign stat_frames       = r_frames;
  assign stat_dropped      = r_dropped;
  assign stat_in_frame     = (r_state == ST_PASS);
  assign stat_dst_active   = w_route_dst;

endmodule

// File: tb/tb_sdr_rx_demux.sv
// Testbench for sdr_rx_demux: a hand-derived vector table, directed corner sequences,
// and random traffic checked against a frame-level reference model.
module tb_sdr_rx_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_dst_sel = 2'd0;
  logic        stat_clr = 1'b0;
  logic [63:0] s_tdata = 64'd0;
  logic [7:0]  s_tkeep = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] dma_tdata, alt_tdata;
  logic [7:0]  dma_tkeep, alt_tkeep;
  logic        dma_tvalid, alt_tvalid, dma_tlast, alt_tlast;
  logic        dma_tready = 1'b0;
  logic        alt_tready = 1'b0;
  logic [31:0] stat_bytes, stat_frames, stat_dropped;
  logic        stat_in_frame;
  logic [1:0]  stat_dst_active;

  sdr_rx_demux #(.AXIS_BYTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable), .cfg_dst_sel(cfg_dst_sel),
    .stat_clr(stat_clr),
    .s_axis_in_tdata(s_tdata), .s_axis_in_tkeep(s_tkeep), .s_axis_in_tvalid(s_tvalid),
    .s_axis_in_tlast(s_tlast), .s_axis_in_tready(s_tready),
    .m_axis_dma_tdata(dma_tdata), .m_axis_dma_tkeep(dma_tkeep), .m_axis_dma_tvalid(dma_tvalid),
    .m_axis_dma_tlast(dma_tlast), .m_axis_dma_tready(dma_tready),
    .m_axis_alt_tdata(alt_tdata), .m_axis_alt_tkeep(alt_tkeep), .m_axis_alt_tvalid(alt_tvalid),
    .m_axis_alt_tlast(alt_tlast), .m_axis_alt_tready(alt_tready),
    .stat_bytes(stat_bytes), .stat_frames(stat_frames), .stat_dropped(stat_dropped),
    .stat_in_frame(stat_in_frame), .stat_dst_active(stat_dst_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats accepted but not yet delivered, frame lock, counters
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  dst;
  } beat_t;

  beat_t       m_q[$];
  logic        m_in_frame = 1'b0;
  logic [1:0]  m_locked = 2'd0;
  logic [31:0] m_bytes = 32'd0, m_frames = 32'd0, m_dropped = 32'd0;

  task automatic model_clear();
    m_q.delete();
    m_in_frame = 1'b0;
    m_locked   = 2'd0;
    m_bytes    = 32'd0;
    m_frames   = 32'd0;
    m_dropped  = 32'd0;
  endtask

  task automatic step(input logic en, input logic [1:0] dst, input logic v,
                      input logic [63:0] d, input logic [7:0] k, input logic l,
                      input logic dr, input logic ar, input logic clr, output logic acc);
    logic       held, drain, en_ok, exp_rdy;
    logic [1:0] route;
    beat_t      hb;
    @(negedge clk);
    cfg_enable = en; cfg_dst_sel = dst; s_tvalid = v; s_tdata = d; s_tkeep = k;
    s_tlast = l; dma_tready = dr; alt_tready = ar; stat_clr = clr;
    #1;
    held  = (m_q.size() > 0);
    hb    = held ? m_q[0] : '0;
    drain = held && ((hb.dst == 2'd0) ? dr : ar);
    en_ok = m_in_frame || en;
    route = m_in_frame ? m_locked : dst;
    exp_rdy = (route >= 2'd2) ? en_ok : (en_ok && (!held || drain));
    chk("tready", s_tready, exp_rdy);
    chk("dma_valid", dma_tvalid, held && hb.dst == 2'd0);
    chk("alt_valid", alt_tvalid, held && hb.dst == 2'd1);
    if (held) begin
      chk("dma_data", dma_tdata, hb.data);
      chk("alt_data", alt_tdata, hb.data);
      chk("out_keep", dma_tkeep, hb.keep);
      chk("out_last", dma_tlast, hb.last);
    end
    chk("in_frame", stat_in_frame, m_in_frame);
    chk("dst_active", stat_dst_active, route);
    chk("stat_bytes", stat_bytes, m_bytes);
    chk("stat_frames", stat_frames, m_frames);
    chk("stat_dropped", stat_dropped, m_dropped);
    acc = v && exp_rdy;
    if (clr) begin
      m_bytes = 32'd0; m_frames = 32'd0; m_dropped = 32'd0;
    end else begin
      if (drain) begin
        m_bytes = m_bytes + 32'($countones(hb.keep));
        if (hb.last) m_frames = m_frames + 32'd1;
      end
      if (acc && route >= 2'd2) m_dropped = m_dropped + 32'd1;
    end
    if (drain) void'(m_q.pop_front());
    if (acc && route < 2'd2) m_q.push_back('{data: d, keep: k, last: l, dst: route});
    if (acc) begin
      if (!m_in_frame && !l) begin
        m_in_frame = 1'b1;
        m_locked   = dst;
      end else if (m_in_frame && l) begin
        m_in_frame = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_tvalid = 1'b0; stat_clr = 1'b0;
    #1;
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_dma_valid", dma_tvalid, 1'b0);
    chk("rst_alt_valid", alt_tvalid, 1'b0);
    chk("rst_bytes", stat_bytes, 32'd0);
    chk("rst_frames", stat_frames, 32'd0);
    chk("rst_dropped", stat_dropped, 32'd0);
    chk("rst_in_frame", stat_in_frame, 1'b0);
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic flush(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b1, 2'd0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, a);
  endtask

  typedef struct {
    logic en; logic [1:0] dst; logic v; logic [63:0] d; logic [7:0] k; logic l;
    logic [1:0] e_dst; logic e_rdy; logic e_dv; logic e_av; logic e_if; logic [63:0] e_d; logic e_l;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic        acc;
    int          nb, guard;
    logic [63:0] rd;

    tbl[0]  = '{1'b1, 2'd0, 1'b1, 64'hA1, 8'hFF, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b1, 64'hA2, 8'hFF, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA1, 1'b0};
    tbl[2]  = '{1'b1, 2'd1, 1'b1, 64'hA3, 8'hFF, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA2, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 1'b1, 64'hA4, 8'hFF, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hA3, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 64'h0,  8'h00, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hA4, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 1'b0, 64'h0,  8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b1, 64'hD1, 8'hFF, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};
    tbl[7]  = '{1'b1, 2'd2, 1'b1, 64'hD2, 8'hFF, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  1'b0};
    tbl[8]  = '{1'b1, 2'd0, 1'b1, 64'hD3, 8'hFF, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  1'b0};
    tbl[9]  = '{1'b1, 2'd2, 1'b1, 64'hD4, 8'hFF, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  1'b0};
    tbl[10] = '{1'b1, 2'd2, 1'b1, 64'hD5, 8'hFF, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0,  1'b0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 64'h0,  8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 64'hE1, 8'hFF, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};
    tbl[13] = '{1'b1, 2'd1, 1'b0, 64'h0,  8'h00, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0};

    do_reset();

    // Vector table: 4-beat DMA frame (dst changes mid-frame), 5-beat DROP frame, enable off
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cfg_enable = tbl[i].en; cfg_dst_sel = tbl[i].dst; s_tvalid = tbl[i].v;
      s_tdata = tbl[i].d; s_tkeep = tbl[i].k; s_tlast = tbl[i].l;
      dma_tready = 1'b1; alt_tready = 1'b1; stat_clr = 1'b0;
      #1;
      chk("tbl_tready", s_tready, tbl[i].e_rdy);
      chk("tbl_dma_valid", dma_tvalid, tbl[i].e_dv);
      chk("tbl_alt_valid", alt_tvalid, tbl[i].e_av);
      chk("tbl_in_frame", stat_in_frame, tbl[i].e_if);
      chk("tbl_dst_active", stat_dst_active, tbl[i].e_dst);
      if (tbl[i].e_dv) begin
        chk("tbl_data", dma_tdata, tbl[i].e_d);
        chk("tbl_last", dma_tlast, tbl[i].e_l);
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    chk("tbl_bytes", stat_bytes, 32'd32);
    chk("tbl_frames", stat_frames, 32'd1);
    chk("tbl_dropped", stat_dropped, 32'd5);

    do_reset();

    // dst 0->1 at beat 2 of a 6-beat frame; next 2-beat frame wholly to ALT
    for (int i = 0; i < 6; i++)
      step(1'b1, (i >= 1) ? 2'd1 : 2'd0, 1'b1, 64'h100 + 64'(i), 8'hFF, i == 5, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 2; i++)
      step(1'b1, 2'd1, 1'b1, 64'h200 + 64'(i), 8'hFF, i == 1, 1'b1, 1'b1, 1'b0, acc);
    flush(3);
    chk("seq_dst_frames", stat_frames, 32'd2);
    chk("seq_dst_bytes", stat_bytes, 32'd64);

    // ALT with tready toggling every cycle, 8-beat frame
    nb = 0; guard = 0;
    while (nb < 8 && guard < 64) begin
      step(1'b1, 2'd1, 1'b1, 64'h300 + 64'(nb), 8'hFF, nb == 7, 1'b1, guard[0], 1'b0, acc);
      if (acc) nb++;
      guard++;
    end
    chk("seq_toggle_beats", nb, 8);
    flush(4);

    // DROP 5-beat frame
    for (int i = 0; i < 5; i++)
      step(1'b1, 2'd2, 1'b1, 64'h400 + 64'(i), 8'hFF, i == 4, 1'b1, 1'b1, 1'b0, acc);
    flush(2);
    chk("seq_drop_count", stat_dropped, 32'd5);

    // stat_clr coinciding with final handshake (tkeep=0x0F)
    step(1'b1, 2'd0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    step(1'b1, 2'd0, 1'b1, 64'h501, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 2'd0, 1'b1, 64'h502, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 2'd0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    chk("clr_pre_bytes", stat_bytes, 32'd8);
    step(1'b1, 2'd0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    chk("clr_bytes", stat_bytes, 32'd0);
    chk("clr_frames", stat_frames, 32'd0);

    // Single-beat ALT frame with partial keep
    step(1'b1, 2'd1, 1'b1, 64'h601, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    flush(2);
    chk("single_bytes", stat_bytes, 32'd4);
    chk("single_frames", stat_frames, 32'd1);
    chk("single_in_frame", stat_in_frame, 1'b0);

    // Enable dropped mid-frame: frame completes, then input is refused
    step(1'b1, 2'd0, 1'b1, 64'h701, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 2'd0, 1'b1, 64'h702, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 2'd0, 1'b1, 64'h703, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 2'd0, 1'b1, 64'h704, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    chk("enable_off_idle", s_tready, 1'b0);
    flush(2);

    // Reset mid-frame with a beat stuck in the holding register
    step(1'b1, 2'd1, 1'b1, 64'h801, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 2'd1, 1'b1, 64'h802, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rd = {$urandom, $urandom};
      step($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
           rd, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0, acc);
    end
    flush(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
